// File: rtl/flop_bank_arbiter.sv
// flop_bank_arbiter
//
// Round-robin write arbiter and clear sequencer for a shared bank of
// enable flip-flops. NREQ requesters compete for one write port into a
// DEPTH x WIDTH register bank, and one write retires per cycle. A sweep
// command clears the bank one entry per cycle. Requests stall while the
// sweep runs.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   req        per-requester write request (level, held until granted)
//   wr_addr    requester i address in [i*AW +: AW]
//   wr_data    requester i data in [i*WIDTH +: WIDTH]
//   sweep      clear-sweep request, sampled each cycle in IDLE
//   gnt        registered one-hot grant pulse
//   bank_q     bank contents, entry k in [k*WIDTH +: WIDTH]
//   busy       high while sweeping (decoded from state)
//   sweep_done one-cycle pulse after the last entry is cleared

module flop_bank_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*AW-1:0]     wr_addr,
    input  logic [NREQ*WIDTH-1:0]  wr_data,
    input  logic                   sweep,
    output logic [NREQ-1:0]        gnt,
    output logic [DEPTH*WIDTH-1:0] bank_q,
    output logic                   busy,
    output logic                   sweep_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     cnt;
    logic [AW-1:0]     cnt_next;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic [NREQ-1:0]   gnt_next;
    logic              done_next;

    logic [WIDTH-1:0]  bank [DEPTH];

    logic [NREQ-1:0]   eligible;
    logic              found;
    logic [PW-1:0]     winner;
    int                cand;

    logic              wr_en;
    logic [AW-1:0]     wr_sel;
    logic [WIDTH-1:0]  wr_val;

    // A requester granted last cycle still has req high this cycle, so it
    // is masked to keep one held request from writing twice.
    assign eligible = req & ~gnt;

    // Round-robin search: walk the requesters starting at ptr, wrapping
    // modulo NREQ, and keep the first eligible one.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = PW'(cand);
            end
        end
    end

    // Next-state and write-port control. Sweep wins over any request in
    // IDLE. While sweeping, the single write port is used to zero the entry
    // under the counter. Requests are ignored, so only one write per cycle
    // ever happens.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ptr_next   = ptr;
        gnt_next   = '0;
        done_next  = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = '0;
        wr_val     = '0;
        case (state)
            IDLE: begin
                if (sweep) begin
                    state_next = SWEEP;
                    cnt_next   = '0;
                end else if (found) begin
                    wr_en    = 1'b1;
                    wr_sel   = wr_addr[winner*AW +: AW];
                    wr_val   = wr_data[winner*WIDTH +: WIDTH];
                    gnt_next = NREQ'(1) << winner;
                    ptr_next = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            SWEEP: begin
                wr_en    = 1'b1;
                wr_sel   = cnt;
                wr_val   = '0;
                cnt_next = cnt + 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control registers: state, sweep counter, rr pointer, and the
    // registered grant and done pulses.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            gnt        <= '0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            ptr        <= ptr_next;
            gnt        <= gnt_next;
            sweep_done <= done_next;
        end
    end

    // The bank itself is made of enable flops. Each entry loads only when
    // it is addressed by the shared write port, and otherwise holds.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                bank[k] <= '0;
            end
        end else if (wr_en) begin
            bank[wr_sel] <= wr_val;
        end
    end

    // Flatten the bank for the output bus.
    for (genvar k = 0; k < DEPTH; k++) begin : g_bank_q
        assign bank_q[k*WIDTH +: WIDTH] = bank[k];
    end

    assign busy = (state == SWEEP);

endmodule

// File: tb/tb_flop_bank_arbiter.sv
// tb_flop_bank_arbiter
//
// Self-checking bench for flop_bank_arbiter with the default parameters
// (NREQ=4, WIDTH=8, DEPTH=4). Each vector is driven for one cycle and its
// expected outputs are queued. After the next rising edge, the outputs are
// compared against the head of the queue.

module tb_flop_bank_arbiter;

    logic        clk;
    logic        clr;
    logic [3:0]  req;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        sweep;
    logic [3:0]  gnt;
    logic [31:0] bank_q;
    logic        busy;
    logic        sweep_done;

    int checks;
    int errors;

    typedef struct packed {
        logic [3:0]  req;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        sweep;
        logic [3:0]  gnt;
        logic [31:0] bank;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t sb [$];
    vec_t tbl [14];

    flop_bank_arbiter #(
        .NREQ (4),
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sweep     (sweep),
        .gnt       (gnt),
        .bank_q    (bank_q),
        .busy      (busy),
        .sweep_done(sweep_done)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the bench always ends by itself.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic [3:0] r, input logic [7:0] a,
                                input logic [31:0] d, input logic s,
                                input logic [3:0] g, input logic [31:0] b,
                                input logic bu, input logic dn);
        vec_t v;
        v.req   = r;
        v.addr  = a;
        v.data  = d;
        v.sweep = s;
        v.gnt   = g;
        v.bank  = b;
        v.busy  = bu;
        v.done  = dn;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req     = v.req;
        wr_addr = v.addr;
        wr_data = v.data;
        sweep   = v.sweep;
        sb.push_back(v);
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got nothing expected entry", tag);
        end else begin
            e = sb.pop_front();
            checkVal({tag, ".gnt"},  32'(gnt),        32'(e.gnt));
            checkVal({tag, ".bank"}, bank_q,          e.bank);
            checkVal({tag, ".busy"}, 32'(busy),       32'(e.busy));
            checkVal({tag, ".done"}, 32'(sweep_done), 32'(e.done));
        end
    endtask

    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, ".gnt"},  32'(gnt),        32'h0);
        checkVal({tag, ".bank"}, bank_q,          32'h0);
        checkVal({tag, ".busy"}, 32'(busy),       32'h0);
        checkVal({tag, ".done"}, 32'(sweep_done), 32'h0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clr     = 1'b0;
        req     = '0;
        wr_addr = '0;
        wr_data = '0;
        sweep   = 1'b0;

        // Round robin from ptr=0 with all four requesting. Requester i writes
        // 8'hC0+i into entry i.
        tbl[0]  = mk(4'b1111, 8'hE4, 32'hC3C2C1C0, 1'b0, 4'b0001, 32'h000000C0, 1'b0, 1'b0);
        tbl[1]  = mk(4'b1111, 8'hE4, 32'hC3C2C1C0, 1'b0, 4'b0010, 32'h0000C1C0, 1'b0, 1'b0);
        tbl[2]  = mk(4'b1111, 8'hE4, 32'hC3C2C1C0, 1'b0, 4'b0100, 32'h00C2C1C0, 1'b0, 1'b0);
        tbl[3]  = mk(4'b1111, 8'hE4, 32'hC3C2C1C0, 1'b0, 4'b1000, 32'hC3C2C1C0, 1'b0, 1'b0);
        tbl[4]  = mk(4'b1111, 8'hE4, 32'hC3C2C1C0, 1'b0, 4'b0001, 32'hC3C2C1C0, 1'b0, 1'b0);
        tbl[5]  = mk(4'b0000, 8'h00, 32'h00000000, 1'b0, 4'b0000, 32'hC3C2C1C0, 1'b0, 1'b0);
        // Single write: requester 0 writes 8'hA5 to entry 2 (ptr=1 wraps to 0).
        tbl[6]  = mk(4'b0001, 8'h02, 32'h000000A5, 1'b0, 4'b0001, 32'hC3A5C1C0, 1'b0, 1'b0);
        tbl[7]  = mk(4'b0000, 8'h00, 32'h00000000, 1'b0, 4'b0000, 32'hC3A5C1C0, 1'b0, 1'b0);
        // Requester 1 writes 8'h5A to entry 1, which moves ptr to 2.
        tbl[8]  = mk(4'b0010, 8'h04, 32'h00005A00, 1'b0, 4'b0010, 32'hC3A55AC0, 1'b0, 1'b0);
        tbl[9]  = mk(4'b0000, 8'h00, 32'h00000000, 1'b0, 4'b0000, 32'hC3A55AC0, 1'b0, 1'b0);
        // Collision on entry 0 with ptr=2: requester 3 goes first, then 1.
        tbl[10] = mk(4'b1010, 8'h00, 32'h33001100, 1'b0, 4'b1000, 32'hC3A55A33, 1'b0, 1'b0);
        tbl[11] = mk(4'b1010, 8'h00, 32'h33001100, 1'b0, 4'b0010, 32'hC3A55A11, 1'b0, 1'b0);
        tbl[12] = mk(4'b0000, 8'h00, 32'h00000000, 1'b0, 4'b0000, 32'hC3A55A11, 1'b0, 1'b0);
        // Requester 2 writes 8'hE7 to entry 1 (ptr=2), so gnt is high for the reset test.
        tbl[13] = mk(4'b0100, 8'h10, 32'h00E70000, 1'b0, 4'b0100, 32'hC3A5E711, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        checkReset("reset_init");
        clr = 1'b1;

        for (int i = 0; i < 14; i++) begin
            runVec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Asynchronous reset between edges while gnt and the bank are nonzero.
        #2;
        clr = 1'b0;
        #1;
        checkReset("async_reset");
        @(posedge clk);
        #1;
        req = '0;
        clr = 1'b1;

        // Fill the bank with 8'hFF through requester 0.
        for (int k = 0; k < 4; k++) begin
            runVec(mk(4'b0001, 8'(k), 32'h000000FF, 1'b0, 4'b0001,
                      32'hFFFFFFFF >> (8 * (3 - k)), 1'b0, 1'b0),
                   $sformatf("fill%0d", k));
            runVec(mk(4'b0000, 8'h00, 32'h0, 1'b0, 4'b0000,
                      32'hFFFFFFFF >> (8 * (3 - k)), 1'b0, 1'b0),
                   $sformatf("fillidle%0d", k));
        end

        // Sweep and request in the same cycle: the sweep wins. It runs for 4
        // busy cycles and ignores both req and a re-asserted sweep. After
        // sweep_done the held request is granted.
        runVec(mk(4'b0001, 8'h01, 32'h0000007E, 1'b1, 4'b0000, 32'hFFFFFFFF, 1'b1, 1'b0), "sw_start");
        runVec(mk(4'b0001, 8'h01, 32'h0000007E, 1'b1, 4'b0000, 32'hFFFFFF00, 1'b1, 1'b0), "sw_clr0");
        runVec(mk(4'b0001, 8'h01, 32'h0000007E, 1'b1, 4'b0000, 32'hFFFF0000, 1'b1, 1'b0), "sw_clr1");
        runVec(mk(4'b0001, 8'h01, 32'h0000007E, 1'b1, 4'b0000, 32'hFF000000, 1'b1, 1'b0), "sw_clr2");
        runVec(mk(4'b0001, 8'h01, 32'h0000007E, 1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b1), "sw_done");
        runVec(mk(4'b0001, 8'h01, 32'h0000007E, 1'b0, 4'b0001, 32'h00007E00, 1'b0, 1'b0), "sw_grant");
        runVec(mk(4'b0000, 8'h00, 32'h00000000, 1'b0, 4'b0000, 32'h00007E00, 1'b0, 1'b0), "sw_idle");

        // Reset two cycles into a sweep. After release, ptr must be back at 0,
        // so requester 0 beats requester 1.
        runVec(mk(4'b0000, 8'h00, 32'h0, 1'b1, 4'b0000, 32'h00007E00, 1'b1, 1'b0), "ms_start");
        runVec(mk(4'b0000, 8'h00, 32'h0, 1'b0, 4'b0000, 32'h00007E00, 1'b1, 1'b0), "ms_clr0");
        #2;
        clr = 1'b0;
        #1;
        checkReset("midsweep_reset");
        @(posedge clk);
        #1;
        clr = 1'b1;
        runVec(mk(4'b0011, 8'h03, 32'h00000099, 1'b0, 4'b0001, 32'h99000000, 1'b0, 1'b0), "ms_grant");
        runVec(mk(4'b0000, 8'h00, 32'h00000000, 1'b0, 4'b0000, 32'h99000000, 1'b0, 1'b0), "ms_idle");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flop_bank_arbiter.md
# flop_bank_arbiter

Round-robin write arbiter and clear sequencer for a shared bank of enable flip-flops. NREQ requesters compete for single-port write access to DEPTH registers of WIDTH bits; one write retires per cycle. A sweep command clears the bank one entry per cycle while requests stall. It sits between requester logic and the flop bank it owns, and exercises async-reset, enable and sync-clear flop mapping in one block.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, bits per bank entry
- DEPTH, 4, bank entries; power of two, 2..16; AW = log2(DEPTH)
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester write request, level, held until granted
- wr_addr  in  NREQ*AW  requester i address in bits [i*AW +: AW]
- wr_data  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- sweep  in  1  clear-sweep request, sampled each cycle
- gnt  out  NREQ  registered one-hot grant/ack pulse
- bank_q  out  DEPTH*WIDTH  bank contents, entry k in [k*WIDTH +: WIDTH]
- busy  out  1  high while sweeping
- sweep_done  out  1  one-cycle pulse after the last entry is cleared

## Operation
- Reset (clr low, async): all bank entries 0, gnt 0, busy 0, sweep_done 0, rr pointer 0, state IDLE, sweep counter 0.
- States: IDLE, SWEEP.
- IDLE, sweep high: go to SWEEP at the edge, counter 0. No write that cycle; sweep wins over any req.
- IDLE, sweep low: eligible = req & ~gnt. Requester i with gnt high is masked that cycle, which prevents a double write from a held req.
- Winner: first eligible index at or after ptr, wrapping modulo NREQ.
- At the edge: bank[wr_addr of winner] <= wr_data of winner; gnt <= onehot(winner); ptr <= (winner+1) mod NREQ.
- No eligible request: gnt <= 0 and ptr unchanged.
- SWEEP: busy = 1. Each cycle, bank[counter] <= 0 and counter increments.
  - When counter = DEPTH-1, that entry is cleared, state returns to IDLE, and sweep_done pulses for the following cycle.
  - Requests are not arbitrated and gnt stays 0. req and sweep are ignored.
- busy is combinational from state: high exactly for DEPTH cycles per sweep.
- Only one bank write per cycle, by construction. Non-addressed entries hold their value.
- Requester protocol: drive req/addr/data stable, then sample gnt[i]. The new value is visible on bank_q in the same cycle gnt[i] is high. Deassert req or present the next write in the cycle after gnt.

## Timing
- Write latency: 1 edge. Request at cycle n with no contention gives gnt and bank_q updated in cycle n+1.
- Worst-case grant wait with all NREQ requesters continuously active: NREQ cycles. Each requester's req is masked the cycle after its grant.
- Sweep: sweep sampled at edge n; busy high cycles n+1..n+DEPTH; sweep_done high cycle n+DEPTH+1; first arbitration possible at edge n+DEPTH+1.
- A sweep asserted while busy is dropped. A sweep held high continuously restarts in the cycle after sweep_done.
- clr low mid-sweep or mid-grant: immediate return to reset values, with no partial write retained beyond what was already clocked.
- Outputs are registered, except busy, which is state-decoded with no input-to-output combinational path.

## Test plan
- Reset: pulse clr low asynchronously between edges with bank nonzero -> bank_q=0, gnt=0, busy=0 immediately, no clock needed.
- Single write: req=0001, addr0=2, data0=8'hA5 -> next cycle gnt=0001, bank_q entry2=8'hA5, others unchanged.
- Round-robin: req=1111 held, distinct addr/data per requester -> gnt sequence 0001,0010,0100,1000,0001 with ptr wrapping; each write lands in its entry.
- Collision: requesters 1 and 3 target addr 0 with 8'h11 / 8'h33, ptr=2 -> gnt 1000 first (entry0=8'h33), then 0010 (entry0=8'h11).
- Sweep vs request: bank full of 8'hFF, sweep=1 and req=0001 in the same cycle -> busy for 4 cycles, entries cleared 0..3 in order, gnt 0 throughout, sweep_done pulse, then gnt=0001 next cycle.
- Reset mid-sweep: clr low after 2 sweep cycles -> busy 0, state IDLE, all entries 0; after release, a single req is granted normally with ptr=0.
